// File: rtl/spi_slave_bmm150_emu_pkg.sv
// Shared types, register map constants and helpers for the BMM150 SPI register emulator.
package spi_slave_bmm150_emu_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA_RD, DATA_WR} state_t;

  localparam logic [6:0] REG_CHIP_ID   = 7'h40;
  localparam logic [6:0] REG_DATA_BASE = 7'h42;
  localparam logic [6:0] REG_PWR_CTRL  = 7'h4B;
  localparam logic [6:0] REG_WIN_BASE  = 7'h40;
  localparam logic [6:0] REG_WIN_TOP   = 7'h7F;
  localparam logic [6:0] RO_TOP        = 7'h4A;

  function automatic logic [7:0] reg_reset_val(input logic [6:0] addr, input logic [7:0] chip_id);
    if (addr == REG_CHIP_ID) return chip_id;
    if (addr == REG_PWR_CTRL) return 8'h01;
    return 8'h00;
  endfunction

  // Burst addressing stays inside the register window by wrapping the top back to the base.
  function automatic logic [6:0] next_addr(input logic [6:0] addr);
    return (addr == REG_WIN_TOP) ? REG_WIN_BASE : addr + 7'd1;
  endfunction

endpackage

// File: rtl/spi_slave_bmm150_emu_if.sv
// SPI pad-side signals of the BMM150 emulator, with master and slave views.
interface spi_slave_bmm150_emu_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_slave_bmm150_emu_in_sync.sv
// Multi-flop synchronizer for an asynchronous SPI input, with registered level and edge pulses.
module spi_in_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  // level, rise and fall update on the same edge so consumers see them aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RESET_VAL}};
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      level <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~level;
      fall  <= ~chain[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_slave_bmm150_emu.sv
// SPI mode-3 responder emulating the BMM150 register window 0x40-0x7F.
// Optional build macro SPI_SLAVE_RO_PROTECT_EN makes 0x40-0x4A read-only over SPI.
module spi_slave_bmm150_emu
  import spi_slave_bmm150_emu_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CHIP_ID     = 8'h32
) (
  input  logic                        clk,
  input  logic                        rst,
  spi_slave_bmm150_emu_if.slave       spi,
  input  logic [63:0]                 sample_data,
  input  logic                        sample_load,
  output logic                        reg_wr_valid,
  output logic [6:0]                  reg_wr_addr,
  output logic [7:0]                  reg_wr_data,
  output logic                        busy,
  output logic                        txn_done
);

  localparam int DATA_IDX = int'(REG_DATA_BASE) - int'(REG_WIN_BASE);

  state_t state_q, state_d;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_ff;
  logic mosi_s, rise_v, fall_v, wr_ok, load_apply;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift, addr, cmd_addr, nxt;
  logic [7:0] rx_byte, tx_shift, rd_cmd, rd_next;
  logic miso_q, got_rise, load_pending;
  logic [63:0] shadow, load_src;
  logic [7:0] regs [64];

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(spi.sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(spi.cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_ff <= '0;
    else     mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], spi.mosi};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    mosi_s     = mosi_ff[SYNC_STAGES-1];
    rise_v     = sclk_rise & ~cs_lvl;
    fall_v     = sclk_fall & ~cs_lvl;
    rx_byte    = {rx_shift, mosi_s};
    cmd_addr   = rx_byte[6:0];
    nxt        = next_addr(addr);
    rd_cmd     = cmd_addr[6] ? regs[cmd_addr[5:0]] : 8'h00;
    rd_next    = nxt[6] ? regs[nxt[5:0]] : 8'h00;
`ifdef SPI_SLAVE_RO_PROTECT_EN
    wr_ok      = addr[6] && (addr > RO_TOP);
`else
    wr_ok      = addr[6];
`endif
    load_apply = (state_q == IDLE) && (sample_load || load_pending);
    load_src   = sample_load ? sample_data : shadow;
    busy        = (state_q != IDLE);
    spi.miso_oe = (state_q == DATA_RD);
    spi.miso    = (state_q == DATA_RD) ? miso_q : 1'b1;
    state_d     = state_q;
    unique case (state_q)
      IDLE:    if (!cs_lvl) state_d = CMD;
      CMD: begin
        if (cs_lvl) state_d = IDLE;
        else if (rise_v && bit_cnt == 3'd7) state_d = rx_byte[7] ? DATA_RD : DATA_WR;
      end
      DATA_RD, DATA_WR: if (cs_lvl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample loads are deferred to IDLE so a burst read never mixes old and new bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      rx_shift     <= '0;
      addr         <= '0;
      tx_shift     <= '0;
      miso_q       <= 1'b1;
      got_rise     <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      txn_done     <= 1'b0;
      shadow       <= '0;
      load_pending <= 1'b0;
      for (int i = 0; i < 64; i++) regs[i] <= reg_reset_val(REG_WIN_BASE | 7'(i), CHIP_ID);
    end else begin
      reg_wr_valid <= 1'b0;
      txn_done     <= (state_q != IDLE) && cs_lvl && got_rise;
      if (load_apply) begin
        for (int i = 0; i < 8; i++) regs[6'(DATA_IDX + i)] <= load_src[8*i +: 8];
        load_pending <= 1'b0;
      end else if (sample_load) begin
        shadow       <= sample_data;
        load_pending <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          bit_cnt  <= '0;
          got_rise <= 1'b0;
          miso_q   <= 1'b1;
        end
        CMD: if (rise_v) begin
          got_rise <= 1'b1;
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_byte[6:0];
          if (bit_cnt == 3'd7) begin
            addr     <= cmd_addr;
            tx_shift <= rd_cmd;
          end
        end
        DATA_RD: begin
          if (fall_v) begin
            miso_q   <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
          if (rise_v) begin
            got_rise <= 1'b1;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              addr     <= nxt;
              tx_shift <= rd_next;
            end
          end
        end
        DATA_WR: if (rise_v) begin
          got_rise <= 1'b1;
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_byte[6:0];
          if (bit_cnt == 3'd7) begin
            if (wr_ok) begin
              regs[addr[5:0]] <= rx_byte;
              reg_wr_valid    <= 1'b1;
              reg_wr_addr     <= addr;
              reg_wr_data     <= rx_byte;
            end
            addr <= nxt;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_bmm150_emu.sv
// Directed self-checking bench for spi_slave_bmm150_emu driving SPI mode 3 from the master side.
module tb_spi_slave_bmm150_emu;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] sample_data;
  logic        sample_load;
  logic        reg_wr_valid;
  logic [6:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        busy;
  logic        txn_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int exp_wr = 0;
  int done_ref;
  logic [6:0] last_addr = '0;
  logic [7:0] last_data = '0;
  logic       oe_seen;
  logic [7:0] rx;
  logic [7:0] exp_ro;

  spi_slave_bmm150_emu_if bus();

  spi_slave_bmm150_emu #(.SYNC_STAGES(2), .CHIP_ID(8'h32)) dut (
    .clk(clk), .rst(rst), .spi(bus), .sample_data(sample_data), .sample_load(sample_load),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .busy(busy), .txn_done(txn_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (txn_done) done_cnt <= done_cnt + 1;
    if (reg_wr_valid) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= reg_wr_addr;
      last_data <= reg_wr_data;
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Shifts nbits of tx MSB-first; miso is captured just before each rising edge.
  task automatic applyStimulus(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus.sclk = 1'b0;
      bus.mosi = tx[i];
      waitClk(8);
      rxb[i]  = bus.miso;
      oe_seen = oe_seen | bus.miso_oe;
      bus.sclk = 1'b1;
      waitClk(8);
    end
  endtask

  task automatic spiStart();
    bus.cs_n = 1'b0;
    waitClk(8);
  endtask

  task automatic spiStop();
    bus.cs_n = 1'b1;
    waitClk(10);
  endtask

  task automatic spiRead1(input logic [6:0] a, output logic [7:0] d);
    logic [7:0] dummy;
    spiStart();
    applyStimulus({1'b1, a}, 8, dummy);
    applyStimulus(8'h00, 8, d);
    spiStop();
  endtask

  task automatic spiWrite1(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    spiStart();
    applyStimulus({1'b0, a}, 8, dummy);
    applyStimulus(d, 8, dummy);
    spiStop();
  endtask

  initial begin
    bus.sclk = 1'b1;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    rst = 1'b1;
    sample_load = 1'b0;
    sample_data = '0;
    waitClk(4);
    rst = 1'b0;
    waitClk(4);

    checkOutput("rst_miso", 32'(bus.miso), 32'd1);
    checkOutput("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_txn_done", 32'(txn_done), 32'd0);
    checkOutput("rst_wr_valid", 32'(reg_wr_valid), 32'd0);
    checkOutput("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(reg_wr_data), 32'd0);

    $display("[TB] read chip id");
    spiStart();
    oe_seen = 1'b0;
    applyStimulus(8'hC0, 8, rx);
    checkOutput("cmd_phase_oe", 32'(oe_seen), 32'd0);
    oe_seen = 1'b0;
    applyStimulus(8'h00, 8, rx);
    checkOutput("chip_id", 32'(rx), 32'h32);
    checkOutput("data_phase_oe", 32'(oe_seen), 32'd1);
    checkOutput("busy_in_txn", 32'(busy), 32'd1);
    spiStop();
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("miso_idle", 32'(bus.miso), 32'd1);
    checkOutput("miso_oe_idle", 32'(bus.miso_oe), 32'd0);
    checkOutput("txn_done_once", 32'(done_cnt), 32'd1);

    $display("[TB] write and read back 0x4B");
    spiRead1(7'h4B, rx);
    checkOutput("pwr_ctrl_reset", 32'(rx), 32'h01);
    spiWrite1(7'h4B, 8'hA5);
    exp_wr++;
    checkOutput("wr_cnt_4b", 32'(wr_cnt), 32'(exp_wr));
    checkOutput("wr_addr_4b", 32'(last_addr), 32'h4B);
    checkOutput("wr_data_4b", 32'(last_data), 32'hA5);
    spiRead1(7'h4B, rx);
    checkOutput("readback_4b", 32'(rx), 32'hA5);

    $display("[TB] sample load and burst read");
    sample_data = 64'h0807060504030201;
    sample_load = 1'b1;
    waitClk(1);
    sample_load = 1'b0;
    waitClk(2);
    spiStart();
    applyStimulus(8'hC2, 8, rx);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'h00, 8, rx);
      checkOutput($sformatf("burst_%0d", k), 32'(rx), 32'(k + 1));
    end
    spiStop();

    $display("[TB] wrap and out-of-window");
    spiWrite1(7'h7F, 8'h5A);
    exp_wr++;
    checkOutput("wr_cnt_7f", 32'(wr_cnt), 32'(exp_wr));
    spiStart();
    applyStimulus(8'hFF, 8, rx);
    applyStimulus(8'h00, 8, rx);
    checkOutput("wrap_7f", 32'(rx), 32'h5A);
    applyStimulus(8'h00, 8, rx);
    checkOutput("wrap_40", 32'(rx), 32'h32);
    spiStop();
    spiRead1(7'h10, rx);
    checkOutput("read_out_of_win", 32'(rx), 32'h00);
    spiWrite1(7'h10, 8'hFF);
    checkOutput("wr_out_of_win", 32'(wr_cnt), 32'(exp_wr));

    $display("[TB] aborted write");
    spiStart();
    applyStimulus(8'h50, 8, rx);
    applyStimulus(8'hF0, 4, rx);
    spiStop();
    checkOutput("abort_no_wr", 32'(wr_cnt), 32'(exp_wr));
    checkOutput("abort_idle", 32'(busy), 32'd0);
    spiRead1(7'h50, rx);
    checkOutput("abort_reg_kept", 32'(rx), 32'h00);

    $display("[TB] no-edge transaction and idle sclk");
    done_ref = done_cnt;
    spiStart();
    spiStop();
    for (int k = 0; k < 4; k++) begin
      bus.sclk = 1'b0;
      waitClk(8);
      bus.sclk = 1'b1;
      waitClk(8);
    end
    checkOutput("no_rise_no_done", 32'(done_cnt), 32'(done_ref));
    checkOutput("cs_high_idle", 32'(busy), 32'd0);
    checkOutput("cs_high_no_wr", 32'(wr_cnt), 32'(exp_wr));

    $display("[TB] load during burst");
    spiStart();
    applyStimulus(8'hC2, 8, rx);
    applyStimulus(8'h00, 8, rx);
    checkOutput("coherent_0", 32'(rx), 32'h01);
    sample_data = 64'h1817161514131211;
    sample_load = 1'b1;
    waitClk(1);
    sample_load = 1'b0;
    applyStimulus(8'h00, 8, rx);
    checkOutput("coherent_1", 32'(rx), 32'h02);
    applyStimulus(8'h00, 8, rx);
    checkOutput("coherent_2", 32'(rx), 32'h03);
    spiStop();
    spiStart();
    applyStimulus(8'hC2, 8, rx);
    applyStimulus(8'h00, 8, rx);
    checkOutput("new_sample_42", 32'(rx), 32'h11);
    applyStimulus(8'h00, 8, rx);
    checkOutput("new_sample_43", 32'(rx), 32'h12);
    spiStop();

    $display("[TB] write to data register 0x42");
    spiWrite1(7'h42, 8'hEE);
`ifdef SPI_SLAVE_RO_PROTECT_EN
    exp_ro = 8'h11;
`else
    exp_wr++;
    exp_ro = 8'hEE;
`endif
    checkOutput("wr_cnt_42", 32'(wr_cnt), 32'(exp_wr));
    spiRead1(7'h42, rx);
    checkOutput("readback_42", 32'(rx), 32'(exp_ro));

    $display("[TB] reset mid-transaction");
    spiStart();
    applyStimulus(8'h4B, 3, rx);
    rst = 1'b1;
    waitClk(1);
    rst = 1'b0;
    bus.cs_n = 1'b1;
    waitClk(10);
    checkOutput("rst_mid_idle", 32'(busy), 32'd0);
    spiRead1(7'h4B, rx);
    checkOutput("rst_mid_pwr", 32'(rx), 32'h01);
    spiRead1(7'h40, rx);
    checkOutput("rst_mid_chip", 32'(rx), 32'h32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
